// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its program memory:
// memory geometry, loader state encoding and the NOP opcode.
package cpu_pkg;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } ld_state_t;

    localparam logic [7:0] NOP_BYTE = 8'h00;
endpackage

// File: rtl/ram64x8.sv
// Single-write-port storage with asynchronous read; contents are not reset.
module ram64x8 #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/prog_mem.sv
// Program memory with byte-stream loader: LOAD accepts the image, FILL zeroes
// the unused tail, RUN releases the CPU and serves asynchronous reads.
module prog_mem
    import cpu_pkg::*;
#(
    parameter int AW    = cpu_pkg::AW,
    parameter int DW    = cpu_pkg::DW,
    parameter int DEPTH = cpu_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          ld_start,
    output logic          cpu_en,
    output logic [AW:0]   ld_count
);
    // Handshake: a byte transfers on a rising edge where ld_valid && ld_ready;
    // ld_data/ld_last are ignored on every other cycle.

    ld_state_t     state;
    ld_state_t     state_next;
    logic [AW-1:0] waddr;
    logic          accept;
    logic          at_top;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    assign accept = (state == LOAD) && ld_valid;
    assign at_top = (waddr == AW'(DEPTH - 1));
    assign we     = accept || (state == FILL);
    assign wdata  = (state == FILL) ? DW'(NOP_BYTE) : ld_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                // The 64th byte completes the image whether or not it is flagged last.
                if (accept) begin
                    if (at_top) begin
                        state_next = RUN;
                    end else if (ld_last) begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (at_top) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (ld_start) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        ld_ready = (state == LOAD);
        cpu_en   = (state == RUN);
        mem_data = (state == RUN) ? rdata : DW'(NOP_BYTE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            waddr    <= '0;
            ld_count <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        waddr    <= waddr + AW'(1);
                        ld_count <= ld_count + (AW + 1)'(1);
                    end
                end
                FILL: waddr <= waddr + AW'(1);
                RUN: begin
                    if (ld_start) begin
                        waddr    <= '0;
                        ld_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    ram64x8 #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (mem_addr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: loads, fill timing, reload, reset mid-load.
module tb_prog_mem;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] mem_addr;
    logic [7:0] mem_data;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       ld_start;
    logic       cpu_en;
    logic [6:0] ld_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_mem dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_start (ld_start),
        .cpu_en   (cpu_en),
        .ld_count (ld_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one byte for exactly one cycle; it must be accepted at that edge.
    task automatic send(input logic [7:0] d, input logic last);
        @(negedge clk);
        check("ready_before_send", ld_ready, 1);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic read_check(input logic [5:0] a, input logic [7:0] exp);
        @(negedge clk);
        mem_addr = a;
        #1;
        check($sformatf("read_addr_%0d", a), mem_data, exp);
    endtask

    // Counts edges until cpu_en rises; called #1 after an edge. Pulses ld_start at
    // edge 10 and checks mem_data stays NOP while stopped.
    task automatic wait_run(output int n, output int nonzero_reads);
        n = 0;
        nonzero_reads = 0;
        while (!cpu_en && n < 200) begin
            if (mem_data !== 8'h00) nonzero_reads++;
            ld_start = (n == 10);
            @(posedge clk);
            #1;
            n++;
        end
        ld_start = 1'b0;
        if (n >= 200) begin
            failures++;
            $display("FAIL wait_run timeout observed=%0d expected<200", n);
        end
    endtask

    int n;
    int nz;

    initial begin
        rst      = 1'b0;
        mem_addr = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        ld_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ld_ready, 1);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_count", ld_count, 0);
        check("rst_mem_data", mem_data, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // Three-byte image; loader keeps valid high and ld_start pulses during FILL.
        send(8'h3F, 1'b0);
        send(8'h81, 1'b0);
        send(8'hC0, 1'b1);
        check("ready_drops_at_last", ld_ready, 0);
        check("count_after_3", ld_count, 3);
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        wait_run(n, nz);
        ld_valid = 1'b0;
        check("fill_edges_k3", n, 61);
        check("nop_while_stopped_k3", nz, 0);
        check("cpu_en_k3", cpu_en, 1);
        read_check(6'd0, 8'h3F);
        read_check(6'd1, 8'h81);
        read_check(6'd2, 8'hC0);
        for (int a = 3; a < 64; a++) read_check(6'(a), 8'h00);
        check("count_k3_run", ld_count, 3);

        // Reload via ld_start; ld_start again during LOAD must do nothing.
        @(negedge clk);
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        check("restart_cpu_en", cpu_en, 0);
        check("restart_ready", ld_ready, 1);
        check("restart_count", ld_count, 0);
        @(negedge clk);
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        check("start_in_load_ready", ld_ready, 1);
        check("start_in_load_count", ld_count, 0);
        send(8'h7E, 1'b1);
        check("count_k1", ld_count, 1);
        wait_run(n, nz);
        check("fill_edges_k1", n, 63);
        check("nop_while_stopped_k1", nz, 0);
        read_check(6'd0, 8'h7E);
        for (int a = 1; a < 64; a++) read_check(6'(a), 8'h00);

        // Full 64-byte image with random idle gaps, never flagged last.
        @(negedge clk);
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(8'(i), 1'b0);
            if (i == 62) check("no_run_before_64th", cpu_en, 0);
        end
        check("run_at_64th_edge", cpu_en, 1);
        check("ready_low_at_64th", ld_ready, 0);
        check("count_64", ld_count, 7'd64);
        // Valid held in RUN is not a transfer.
        ld_valid = 1'b1;
        ld_data  = 8'hFF;
        ld_last  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("count_64_hold", ld_count, 7'd64);
        for (int a = 0; a < 64; a++) read_check(6'(a), 8'(a));

        // Reset in the middle of a load, then a short reload.
        @(negedge clk);
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        for (int i = 0; i < 10; i++) send(8'hA0 + 8'(i), 1'b0);
        check("count_10", ld_count, 10);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("midreset_count", ld_count, 0);
        check("midreset_ready", ld_ready, 1);
        check("midreset_cpu_en", cpu_en, 0);
        mem_addr = 6'd0;
        check("midreset_mem_data", mem_data, 8'h00);
        send(8'hAA, 1'b0);
        send(8'h55, 1'b1);
        check("count_k2", ld_count, 2);
        wait_run(n, nz);
        check("fill_edges_k2", n, 62);
        check("nop_while_stopped_k2", nz, 0);
        read_check(6'd0, 8'hAA);
        read_check(6'd1, 8'h55);
        for (int a = 2; a < 64; a++) read_check(6'(a), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
